// File: rtl/elevator_scheduler.sv
// Eight-floor elevator car scheduler using SCAN ordering: it keeps moving one way while
// calls remain ahead, then reverses. Floor travel and door dwell are timed in enabled ticks.
module elevator_scheduler #(
  parameter int FLOOR_TICKS = 16,
  parameter int DOOR_TICKS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] destination,
  output logic [1:0] sim_state,
  output logic [2:0] current_floor
);

  // state       | meaning
  // ST_IDLE     | parked, evaluating pending calls every cycle
  // ST_UP       | travelling toward a higher floor
  // ST_DOWN     | travelling toward a lower floor
  // ST_DOOR     | door open at current_floor, dwell timer running
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_UP   = 2'b01;
  localparam logic [1:0] ST_DOWN = 2'b10;
  localparam logic [1:0] ST_DOOR = 2'b11;

  localparam int TICK_MAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [TW-1:0] FLOOR_LAST = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LAST  = TW'(DOOR_TICKS - 1);

  logic [1:0]    r_state;
  logic [7:0]    r_dest;
  logic [2:0]    r_floor;
  logic          r_dir;
  logic [TW-1:0] r_travel_tmr;
  logic [TW-1:0] r_door_tmr;

  logic [1:0]    w_state_n;
  logic [7:0]    w_dest_n;
  logic [2:0]    w_floor_n;
  logic          w_dir_n;
  logic [TW-1:0] w_travel_n;
  logic [TW-1:0] w_door_n;

  logic [7:0] w_floor_onehot;
  logic [7:0] w_above_mask;
  logic [7:0] w_below_mask;
  logic       w_pend_up;
  logic       w_pend_dn;
  logic       w_ahead;
  logic       w_behind;
  logic [1:0] w_move_state;
  logic       w_move_dir;
  logic [2:0] w_step_floor;
  logic [7:0] w_step_onehot;
  logic       w_step_hit;
  logic       w_req_here;
  logic [7:0] w_set_mask;
  logic [7:0] w_clr_mask;

  assign w_floor_onehot = 8'd1 << r_floor;
  assign w_above_mask   = ~((8'd2 << r_floor) - 8'd1);
  assign w_below_mask   = (8'd1 << r_floor) - 8'd1;
  assign w_pend_up      = |(r_dest & w_above_mask);
  assign w_pend_dn      = |(r_dest & w_below_mask);
  assign w_ahead        = r_dir ? w_pend_up : w_pend_dn;
  assign w_behind       = r_dir ? w_pend_dn : w_pend_up;

  // Shared by IDLE and door expiry: keep going while calls lie ahead, else turn around.
  always_comb begin
    w_move_state = ST_IDLE;
    w_move_dir   = r_dir;
    if (w_ahead) begin
      w_move_state = r_dir ? ST_UP : ST_DOWN;
    end else if (w_behind) begin
      w_move_state = r_dir ? ST_DOWN : ST_UP;
      w_move_dir   = ~r_dir;
    end
  end

  assign w_step_floor  = (r_state == ST_UP) ? (r_floor + 3'd1) : (r_floor - 3'd1);
  assign w_step_onehot = 8'd1 << w_step_floor;
  // A call landing on the arrival edge still stops the car there.
  assign w_step_hit    = |((r_dest | req) & w_step_onehot);
  assign w_req_here    = |(req & w_floor_onehot);

  always_comb begin
    w_state_n  = r_state;
    w_floor_n  = r_floor;
    w_dir_n    = r_dir;
    w_travel_n = r_travel_tmr;
    w_door_n   = r_door_tmr;
    w_clr_mask = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (|(r_dest & w_floor_onehot)) begin
          w_state_n  = ST_DOOR;
          w_clr_mask = w_floor_onehot;
        end else begin
          w_state_n = w_move_state;
          w_dir_n   = w_move_dir;
        end
      end
      ST_UP, ST_DOWN: begin
        if (en) begin
          if (r_travel_tmr == FLOOR_LAST) begin
            w_floor_n  = w_step_floor;
            w_travel_n = '0;
            if (w_step_hit) begin
              w_state_n  = ST_DOOR;
              w_clr_mask = w_step_onehot;
            end
          end else begin
            w_travel_n = r_travel_tmr + 1'b1;
          end
        end
      end
      ST_DOOR: begin
        // A hall call at the open floor only extends the dwell, even with en low.
        if (w_req_here) begin
          w_door_n = '0;
        end else if (en) begin
          if (r_door_tmr == DOOR_LAST) begin
            w_state_n = w_move_state;
            w_dir_n   = w_move_dir;
          end else begin
            w_door_n = r_door_tmr + 1'b1;
          end
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
    if (w_state_n != r_state) begin
      w_travel_n = '0;
      w_door_n   = '0;
    end
  end

  assign w_set_mask = (r_state == ST_DOOR) ? (req & ~w_floor_onehot) : req;
  assign w_dest_n   = (r_dest | w_set_mask) & ~w_clr_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_dest       <= 8'h00;
      r_floor      <= 3'd0;
      r_dir        <= 1'b1;
      r_travel_tmr <= '0;
      r_door_tmr   <= '0;
    end else begin
      r_state      <= w_state_n;
      r_dest       <= w_dest_n;
      r_floor      <= w_floor_n;
      r_dir        <= w_dir_n;
      r_travel_tmr <= w_travel_n;
      r_door_tmr   <= w_door_n;
    end
  end

  assign destination   = r_dest;
  assign sim_state     = r_state;
  assign current_floor = r_floor;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus random calls, compared every cycle
// against a floor/queue-level model of the car.
module tb_elevator_scheduler;

  localparam int FT = 4;
  localparam int DT = 3;
  localparam int PH_IDLE = 0;
  localparam int PH_UP   = 1;
  localparam int PH_DOWN = 2;
  localparam int PH_DOOR = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] destination;
  logic [1:0] sim_state;
  logic [2:0] current_floor;

  elevator_scheduler #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .req(req),
    .destination(destination),
    .sim_state(sim_state),
    .current_floor(current_floor)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference car: pending calls as an array, position as an integer floor,
  // direction as +1/-1 and remaining enabled ticks for travel / door dwell.
  bit m_pend[8];
  int m_floor;
  int m_phase;
  int m_dir;
  int m_travel_left;
  int m_door_left;

  logic [7:0] r_rand;
  logic       e_rand;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_dest();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit pend_toward(input int d);
    for (int f = m_floor + d; f >= 0 && f <= 7; f += d)
      if (m_pend[f]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
    m_floor = 0;
    m_phase = PH_IDLE;
    m_dir = 1;
    m_travel_left = FT;
    m_door_left = DT;
  endtask

  task automatic model_choose();
    if (pend_toward(m_dir)) begin
      m_phase = (m_dir > 0) ? PH_UP : PH_DOWN;
      m_travel_left = FT;
    end else if (pend_toward(-m_dir)) begin
      m_dir = -m_dir;
      m_phase = (m_dir > 0) ? PH_UP : PH_DOWN;
      m_travel_left = FT;
    end else begin
      m_phase = PH_IDLE;
    end
  endtask

  task automatic model_step(input logic [7:0] r, input logic e);
    int f0, ph0, clr_idx;
    f0 = m_floor;
    ph0 = m_phase;
    clr_idx = -1;
    case (m_phase)
      PH_IDLE: begin
        if (m_pend[m_floor]) begin
          m_phase = PH_DOOR;
          m_door_left = DT;
          clr_idx = m_floor;
        end else begin
          model_choose();
        end
      end
      PH_UP, PH_DOWN: begin
        if (e) begin
          m_travel_left--;
          if (m_travel_left == 0) begin
            m_floor += m_dir;
            if (m_pend[m_floor] || r[m_floor]) begin
              m_phase = PH_DOOR;
              m_door_left = DT;
              clr_idx = m_floor;
            end else begin
              m_travel_left = FT;
            end
          end
        end
      end
      default: begin
        if (r[m_floor]) begin
          m_door_left = DT;
        end else if (e) begin
          m_door_left--;
          if (m_door_left == 0) model_choose();
        end
      end
    endcase
    for (int i = 0; i < 8; i++)
      if (r[i] && !(ph0 == PH_DOOR && i == f0)) m_pend[i] = 1'b1;
    if (clr_idx >= 0) m_pend[clr_idx] = 1'b0;
  endtask

  task automatic check_all();
    check_val("dest", destination, model_dest());
    check_val("state", sim_state, m_phase);
    check_val("floor", current_floor, m_floor);
  endtask

  task automatic cyc(input logic [7:0] r, input logic e);
    req = r;
    en = e;
    @(posedge clk);
    model_step(r, e);
    #1;
    check_all();
  endtask

  // Reset is raised between clock edges so its effect must be visible before any edge.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    req = 8'h00;
    #1;
    check_val("rst_async_dest", destination, 8'h00);
    check_val("rst_async_state", sim_state, 2'd0);
    check_val("rst_async_floor", current_floor, 3'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  task automatic wait_dut(input logic [1:0] st, input logic [2:0] fl, input logic [7:0] r,
                          input int budget, input string tag);
    int n;
    n = 0;
    while (!(sim_state == st && current_floor == fl) && n < budget) begin
      cyc(r, 1'b1);
      n++;
    end
    check_val(tag, {sim_state, current_floor}, {st, fl});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    req = 8'h00;
    model_reset();
    @(posedge clk);
    #1;
    check_val("por_dest", destination, 8'h00);
    check_val("por_state", sim_state, 2'd0);
    check_val("por_floor", current_floor, 3'd0);
    rst = 1'b0;

    // basic travel to floor 3
    do_reset();
    cyc(8'h08, 1'b1);
    check_val("basic_dest", destination, 8'h08);
    check_val("basic_idle", sim_state, 2'd0);
    cyc(8'h00, 1'b1);
    check_val("basic_move", sim_state, 2'd1);
    wait_dut(2'd3, 3'd3, 8'h00, 20, "basic_arrive");
    check_val("basic_clr", destination, 8'h00);
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b1);
    check_val("basic_door", sim_state, 2'd3);
    cyc(8'h00, 1'b1);
    check_val("basic_close", sim_state, 2'd0);

    // SCAN: serve 7 before reversing to 1
    do_reset();
    cyc(8'h80, 1'b1);
    wait_dut(2'd1, 3'd3, 8'h00, 30, "scan_at3");
    cyc(8'h02, 1'b1);
    check_val("scan_dest", destination, 8'h82);
    wait_dut(2'd3, 3'd7, 8'h00, 30, "scan_serve7");
    wait_dut(2'd2, 3'd7, 8'h00, 10, "scan_reverse");
    wait_dut(2'd3, 3'd1, 8'h00, 40, "scan_serve1");
    wait_dut(2'd0, 3'd1, 8'h00, 10, "scan_idle");
    check_val("scan_dest_end", destination, 8'h00);

    // door reopen
    do_reset();
    cyc(8'h08, 1'b1);
    wait_dut(2'd3, 3'd3, 8'h00, 30, "reopen_reach");
    cyc(8'h00, 1'b1);
    cyc(8'h08, 1'b1);
    check_val("reopen_dest3", destination[3], 1'b0);
    check_val("reopen_open0", sim_state, 2'd3);
    for (int i = 0; i < 2; i++) begin
      cyc(8'h00, 1'b1);
      check_val("reopen_open", sim_state, 2'd3);
    end
    cyc(8'h00, 1'b1);
    check_val("reopen_close", sim_state, 2'd0);

    // enable gating mid-travel
    do_reset();
    cyc(8'h40, 1'b1);
    wait_dut(2'd1, 3'd2, 8'h00, 30, "gate_reach");
    for (int i = 0; i < 10; i++) begin
      cyc((i == 3) ? 8'h01 : 8'h00, 1'b0);
      check_val("gate_floor", current_floor, 3'd2);
      check_val("gate_state", sim_state, 2'd1);
    end
    check_val("gate_dest0", destination[0], 1'b1);
    wait_dut(2'd3, 3'd6, 8'h00, 40, "gate_serve6");
    wait_dut(2'd3, 3'd0, 8'h00, 60, "gate_serve0");
    wait_dut(2'd0, 3'd0, 8'h00, 10, "gate_idle");

    // async reset while moving at floor 5 with calls pending
    do_reset();
    cyc(8'hC0, 1'b1);
    wait_dut(2'd1, 3'd5, 8'h00, 40, "ar_reach5");
    cyc(8'h01, 1'b1);
    check_val("ar_pre_dest", destination, 8'hC1);
    do_reset();
    cyc(8'h04, 1'b1);
    check_val("ar_resume_dest", destination, 8'h04);
    wait_dut(2'd0, 3'd2, 8'h00, 30, "ar_resume_done");

    // boundaries: hold calls at floors 0 and 7
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(8'h01, 1'b1);
      check_val("b0_floor", current_floor, 3'd0);
    end
    check_val("b0_door", sim_state, 2'd3);
    check_val("b0_dest", destination, 8'h00);
    wait_dut(2'd0, 3'd0, 8'h00, 10, "b0_idle");
    cyc(8'h80, 1'b1);
    wait_dut(2'd3, 3'd7, 8'h00, 40, "b7_reach");
    wait_dut(2'd0, 3'd7, 8'h00, 10, "b7_idle");
    for (int i = 0; i < 6; i++) begin
      cyc(8'h80, 1'b1);
      check_val("b7_floor", current_floor, 3'd7);
    end
    check_val("b7_door", sim_state, 2'd3);
    wait_dut(2'd0, 3'd7, 8'h00, 10, "b7_done");

    // random traffic with occasional enable drops and async resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) begin
        do_reset();
      end else begin
        r_rand = ($urandom_range(5) == 0) ? (8'd1 << $urandom_range(7)) : 8'h00;
        if ($urandom_range(40) == 0) r_rand = 8'($urandom);
        e_rand = ($urandom_range(9) != 0);
        cyc(r_rand, e_rand);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
